// File: rtl/sm_accumulator.sv
// sm_accumulator: sign-magnitude frame accumulator with valid/ready output.
// Sums up to COUNT sign-magnitude operands per frame into a wider
// sign-magnitude register. A frame ends on the COUNT-th accept or on an
// accept with in_last. One result is emitted per frame.
// Build option: define SM_ACC_SATURATE_EN to clamp the magnitude on
// overflow. Without it, the magnitude wraps. Either way the sticky
// out_overflow flag is reported.
module sm_accumulator #(
    parameter int WORD_LENGTH = 16,
    parameter int ACC_LENGTH  = 24,
    parameter int COUNT       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_LENGTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_LENGTH-1:0] out_data,
    output logic                  out_overflow
);
    localparam int MW = ACC_LENGTH - 1;
    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

    typedef enum logic {ACCUM, DONE} state_t;

    state_t          state, state_nxt;
    logic [MW-1:0]   acc_mag;
    logic            acc_sign;
    logic            ovf;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic            frame_end;
    logic [MW-1:0]   in_mag;
    logic            in_sign;
    logic [MW:0]     sum;
    logic [MW-1:0]   new_mag;
    logic            new_sign;
    logic            new_ovf;

    assign in_ready  = (state == ACCUM) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign frame_end = accept && (in_last || (cnt == CW'(COUNT - 1)));

    assign out_data     = rst ? '0 : {acc_sign, acc_mag};
    assign out_overflow = rst ? 1'b0 : ovf;

    // Sign-magnitude add of the incoming operand onto the accumulator.
    always_comb begin
        in_mag = '0;
        in_mag[WORD_LENGTH-2:0] = in_data[WORD_LENGTH-2:0];
        // -0 on the input behaves as +0
        in_sign  = in_data[WORD_LENGTH-1] && (in_mag != '0);
        sum      = {1'b0, acc_mag} + {1'b0, in_mag};
        new_mag  = '0;
        new_sign = 1'b0;
        new_ovf  = 1'b0;
        if (in_sign == acc_sign) begin
            new_sign = acc_sign;
            new_ovf  = sum[MW];
`ifdef SM_ACC_SATURATE_EN
            new_mag  = sum[MW] ? {MW{1'b1}} : sum[MW-1:0];
`else
            new_mag  = sum[MW-1:0];
`endif
        end else if (acc_mag >= in_mag) begin
            new_mag  = acc_mag - in_mag;
            new_sign = acc_sign;
        end else begin
            new_mag  = in_mag - acc_mag;
            new_sign = in_sign;
        end
        // never store -0
        if (new_mag == '0) new_sign = 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // Next-state: close the frame on its final accept, reopen on handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (frame_end) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Accumulator, sticky overflow and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_mag  <= '0;
            acc_sign <= 1'b0;
            ovf      <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            acc_mag  <= new_mag;
            acc_sign <= new_sign;
            ovf      <= ovf | new_ovf;
            cnt      <= frame_end ? '0 : cnt + 1'b1;
        end else if (state == DONE && out_ready) begin
            acc_mag  <= '0;
            acc_sign <= 1'b0;
            ovf      <= 1'b0;
        end
    end
endmodule
